// File: rtl/yarp_data_mem.sv
// ---------------------------------------------------------------------------
// yarp_data_mem
//   Load/store unit sitting after the RV32I execute stage. Takes the ALU
//   result as the effective address and runs at most one transaction at a
//   time on a req/gnt + rvalid data-memory bus. Returns aligned and extended
//   load data, or the ALU result for non-memory ops, as a one-cycle response.
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   req_valid_i / req_ready_o  access handshake from execute (ready in IDLE)
//   alu_res_i                  effective address / passthrough value
//   store_data_i               rs2 value for stores
//   mem_rd_i, mem_wr_i         load / store (store wins if both set)
//   size_i, zero_extnd_i       0=byte 1=half 2,3=word; LBU/LHU select
//   bus_req_o / bus_gnt_i      bus request, held until granted
//   bus_we_o, bus_addr_o,
//   bus_be_o, bus_wdata_o      write flag, word address, byte enables, data
//   bus_rvalid_i, bus_rdata_i  read data return
//   rsp_valid_o, rsp_data_o,
//   rsp_err_o                  result pulse; err 00 ok, 01 misaligned,
//                              10 timeout
// ---------------------------------------------------------------------------
module yarp_data_mem #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] alu_res_i,
    input  logic [31:0] store_data_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [1:0]  size_i,
    input  logic        zero_extnd_i,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic [1:0]  rsp_err_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_MISAL = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;

    // The counter holds the index (0-based) of the current REQ/WAIT cycle,
    // so it never needs to exceed TIMEOUT_CYC-1.
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    state_t           state_q, state_d;
    logic             accept;
    logic             in_mem;
    logic             in_misal;
    logic             timeout_hit;

    logic             wr_q;
    logic [1:0]       size_q;
    logic             zext_q;
    logic [1:0]       lane_q;
    logic [CNT_W-1:0] tmo_cnt_q;

    logic [3:0]       be_d;
    logic [31:0]      wdata_d;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_data;
    logic [31:0]      rsp_data_d;
    logic [1:0]       rsp_err_d;

    assign req_ready_o = (state_q == IDLE);
    assign accept      = req_valid_i & req_ready_o;
    assign in_mem      = mem_rd_i | mem_wr_i;
    assign in_misal    = ((size_i == 2'd1) & alu_res_i[0])
                       | (size_i[1] & (|alu_res_i[1:0]));
    // Fires in the last permitted REQ/WAIT cycle.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (tmo_cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // A completion in the final allowed cycle wins over the timeout; a load
    // granted in that cycle cannot complete in time and is aborted.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!in_mem || in_misal) state_d = RESP;
                    else                     state_d = REQ;
                end
            end
            REQ: begin
                if (bus_gnt_i && wr_q) state_d = RESP;
                else if (timeout_hit)  state_d = RESP;
                else if (bus_gnt_i)    state_d = WAIT;
            end
            WAIT: begin
                if (bus_rvalid_i)     state_d = RESP;
                else if (timeout_hit) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        be_d    = 4'hF;
        wdata_d = store_data_i;
        case (size_i)
            2'd0: begin
                be_d    = 4'b0001 << alu_res_i[1:0];
                wdata_d = {4{store_data_i[7:0]}};
            end
            2'd1: begin
                be_d    = 4'b0011 << alu_res_i[1:0];
                wdata_d = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase

        byte_sel = bus_rdata_i[{lane_q, 3'b000} +: 8];
        half_sel = bus_rdata_i[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'd0:    load_data = zero_extnd_q_ext(zext_q, byte_sel);
            2'd1:    load_data = zext_q ? {16'h0000, half_sel}
                                        : {{16{half_sel[15]}}, half_sel};
            default: load_data = bus_rdata_i;
        endcase

        // Only consumed on the cycle the FSM enters RESP.
        rsp_data_d = '0;
        rsp_err_d  = ERR_OK;
        case (state_q)
            IDLE: begin
                if (!in_mem)       rsp_data_d = alu_res_i;
                else if (in_misal) rsp_err_d  = ERR_MISAL;
            end
            REQ: begin
                if (!(bus_gnt_i && wr_q)) rsp_err_d = ERR_TMO;
            end
            WAIT: begin
                if (bus_rvalid_i) rsp_data_d = load_data;
                else              rsp_err_d  = ERR_TMO;
            end
            default: ;
        endcase
    end

    function automatic logic [31:0] zero_extnd_q_ext(input logic zx,
                                                     input logic [7:0] b);
        return zx ? {24'h000000, b} : {{24{b[7]}}, b};
    endfunction

    // ------------------------------------------------------------------
    // Request capture and timeout counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q      <= 1'b0;
            size_q    <= '0;
            zext_q    <= 1'b0;
            lane_q    <= '0;
            tmo_cnt_q <= '0;
        end else if (accept) begin
            wr_q      <= mem_wr_i;
            size_q    <= size_i;
            zext_q    <= zero_extnd_i;
            lane_q    <= alu_res_i[1:0];
            tmo_cnt_q <= '0;
        end else if ((state_q == REQ || state_q == WAIT) && tmo_cnt_q != CNT_LAST) begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registered bus and response outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= '0;
        end else begin
            bus_req_o   <= (state_d == REQ);
            rsp_valid_o <= (state_d == RESP);
            if (accept && state_d == REQ) begin
                bus_we_o    <= mem_wr_i;
                bus_addr_o  <= {alu_res_i[31:2], 2'b00};
                bus_be_o    <= be_d;
                bus_wdata_o <= wdata_d;
            end
            if (state_d == RESP && state_q != RESP) begin
                rsp_data_o <= rsp_data_d;
                rsp_err_o  <= rsp_err_d;
            end
        end
    end

endmodule

// File: tb/tb_yarp_data_mem.sv
// ---------------------------------------------------------------------------
// tb_yarp_data_mem
//   Table of directed accesses plus randomized accesses checked against a
//   behavioural model, and hand-written reset-during-access sequences.
// ---------------------------------------------------------------------------
module tb_yarp_data_mem;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] alu_res_i;
    logic [31:0] store_data_i;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [1:0]  size_i;
    logic        zero_extnd_i;
    logic        bus_req_o;
    logic        bus_gnt_i;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic [1:0]  rsp_err_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    yarp_data_mem #(.TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .alu_res_i    (alu_res_i),
        .store_data_i (store_data_i),
        .mem_rd_i     (mem_rd_i),
        .mem_wr_i     (mem_wr_i),
        .size_i       (size_i),
        .zero_extnd_i (zero_extnd_i),
        .bus_req_o    (bus_req_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_err_o    (rsp_err_o)
    );

    // g: REQ cycle (1-based) in which the grant is given, 0 = never.
    // w: cycles after the grant cycle at which rvalid arrives.
    // exp_cyc: cycle after accept (accept cycle = 0) where rsp_valid_o is high.
    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        zext;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          g;
        int          w;
        int          exp_cyc;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        int          exp_req;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic rd, input logic wr, input logic [1:0] size,
                                 input logic zext, input logic [31:0] addr,
                                 input logic [31:0] sdata, input logic [31:0] rdata,
                                 input int g, input int w, input int cyc,
                                 input logic [31:0] data, input logic [1:0] err,
                                 input logic [3:0] be, input logic [31:0] wdata,
                                 input int req);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.zext = zext; v.addr = addr;
        v.sdata = sdata; v.rdata = rdata; v.g = g; v.w = w;
        v.exp_cyc = cyc; v.exp_data = data; v.exp_err = err;
        v.exp_be = be; v.exp_wdata = wdata; v.exp_req = req;
        return v;
    endfunction

    // Reference model: access width in bytes, lanes covered, and a budget of
    // TMO bus cycles (REQ+WAIT) before the access is aborted.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int unsigned n;
        int unsigned a_lo;
        logic [63:0] lane;
        r    = v;
        a_lo = int'(v.addr[1:0]);
        n    = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        r.exp_be = '0;
        for (int unsigned i = 0; i < 4; i++)
            if (i >= a_lo && i < a_lo + n) r.exp_be[i] = 1'b1;
        if (n == 1)      r.exp_wdata = {24'h0, v.sdata[7:0]} * 32'h01010101;
        else if (n == 2) r.exp_wdata = {16'h0, v.sdata[15:0]} * 32'h00010001;
        else             r.exp_wdata = v.sdata;
        r.exp_cyc  = 1;
        r.exp_data = '0;
        r.exp_err  = 2'd0;
        r.exp_req  = 0;
        if (!v.rd && !v.wr) begin
            r.exp_data = v.addr;
        end else if (v.addr % n != 0) begin
            r.exp_err = 2'd1;
        end else begin
            r.exp_req = (v.g >= 1 && v.g <= TMO) ? v.g : TMO;
            if (v.wr) begin
                if (v.g >= 1 && v.g <= TMO) r.exp_cyc = v.g + 1;
                else begin r.exp_cyc = TMO + 1; r.exp_err = 2'd2; end
            end else if (v.g >= 1 && v.g + v.w <= TMO) begin
                r.exp_cyc = v.g + v.w + 1;
                lane = {32'h0, v.rdata} >> (8 * a_lo);
                if (n < 4) begin
                    lane = lane % (64'd1 << (8 * n));
                    if (!v.zext && lane >= (64'd1 << (8 * n - 1)))
                        lane = lane - (64'd1 << (8 * n));
                end
                r.exp_data = lane[31:0];
            end else begin
                r.exp_cyc = TMO + 1;
                r.exp_err = 2'd2;
            end
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one access from IDLE, plays the bus slave and checks the result.
    task automatic run_access(input vec_t v, input string tag);
        int          rsp_cyc, rsp_cnt, req_cnt, gnt_cyc;
        logic [31:0] rdat;
        logic [1:0]  rerr;
        logic [31:0] f_addr, f_wdata;
        logic [3:0]  f_be;
        logic        f_we;
        logic        stable;
        chk({tag, " ready"}, req_ready_o, 1);
        req_valid_i  = 1'b1;
        mem_rd_i     = v.rd;
        mem_wr_i     = v.wr;
        size_i       = v.size;
        zero_extnd_i = v.zext;
        alu_res_i    = v.addr;
        store_data_i = v.sdata;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        step();
        req_valid_i  = 1'b0;
        alu_res_i    = $urandom;
        store_data_i = $urandom;
        size_i       = 2'($urandom);
        zero_extnd_i = 1'($urandom);
        mem_rd_i     = 1'($urandom);
        mem_wr_i     = 1'($urandom);
        rsp_cyc = 0; rsp_cnt = 0; req_cnt = 0; gnt_cyc = 0;
        rdat = 'x; rerr = 'x; stable = 1'b1;
        f_addr = 'x; f_wdata = 'x; f_be = 'x; f_we = 'x;
        for (int k = 1; k <= 12; k++) begin
            if (rsp_valid_o) begin
                rsp_cnt++;
                if (rsp_cyc == 0) begin
                    rsp_cyc = k; rdat = rsp_data_o; rerr = rsp_err_o;
                end
            end
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = 1'b0;
            bus_rdata_i  = $urandom;
            if (bus_req_o) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    f_addr = bus_addr_o; f_be = bus_be_o; f_we = bus_we_o; f_wdata = bus_wdata_o;
                end else if (bus_addr_o !== f_addr || bus_be_o !== f_be ||
                             bus_we_o !== f_we || bus_wdata_o !== f_wdata) begin
                    stable = 1'b0;
                end
                bus_rvalid_i = 1'($urandom);   // must be ignored while requesting
                if (req_cnt == v.g) begin
                    bus_gnt_i = 1'b1;
                    gnt_cyc   = k;
                end
            end
            if (v.rd && !v.wr && gnt_cyc != 0 && k == gnt_cyc + v.w) begin
                bus_rvalid_i = 1'b1;
                bus_rdata_i  = v.rdata;
            end
            step();
        end
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        chk({tag, " rsp_cycle"}, rsp_cyc, v.exp_cyc);
        chk({tag, " rsp_pulses"}, rsp_cnt, 1);
        chk({tag, " rsp_data"}, rdat, v.exp_data);
        chk({tag, " rsp_err"}, {30'h0, rerr}, {30'h0, v.exp_err});
        chk({tag, " bus_req_cycles"}, req_cnt, v.exp_req);
        if (v.exp_req > 0) begin
            chk({tag, " bus_addr"}, f_addr, {v.addr[31:2], 2'b00});
            chk({tag, " bus_be"}, {28'h0, f_be}, {28'h0, v.exp_be});
            chk({tag, " bus_we"}, f_we, v.wr);
            if (v.wr) chk({tag, " bus_wdata"}, f_wdata, v.exp_wdata);
            chk({tag, " bus_stable"}, stable, 1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[17];
        vec_t v;
        int   cnt;

        tbl[0]  = mkv(1,0,2,0,32'h100,32'h11111111,32'hDEADBEEF,1,1, 3,32'hDEADBEEF,0,4'hF,32'h11111111,1);
        tbl[1]  = mkv(1,0,0,0,32'h103,32'h0,32'h80123456,1,1, 3,32'hFFFFFF80,0,4'h8,32'h0,1);
        tbl[2]  = mkv(1,0,0,1,32'h103,32'h0,32'h80123456,1,1, 3,32'h00000080,0,4'h8,32'h0,1);
        tbl[3]  = mkv(0,1,1,0,32'h202,32'h1234ABCD,32'h0,4,1, 5,32'h0,0,4'hC,32'hABCDABCD,4);
        tbl[4]  = mkv(1,0,2,0,32'h101,32'h0,32'h0,1,1, 1,32'h0,1,4'h0,32'h0,0);
        tbl[5]  = mkv(0,0,2,0,32'h55,32'h0,32'h0,1,1, 1,32'h55,0,4'h0,32'h0,0);
        tbl[6]  = mkv(0,1,2,0,32'h300,32'h5A5A0F0F,32'h0,0,1, 5,32'h0,2,4'hF,32'h5A5A0F0F,4);
        tbl[7]  = mkv(1,0,1,0,32'h106,32'h0,32'h80017FFF,2,2, 5,32'hFFFF8001,0,4'hC,32'h0,2);
        tbl[8]  = mkv(1,0,1,1,32'h104,32'h0,32'h1234F00D,1,1, 3,32'h0000F00D,0,4'h3,32'h0,1);
        tbl[9]  = mkv(1,0,2,0,32'h108,32'h0,32'h12345678,2,3, 5,32'h0,2,4'hF,32'h0,2);
        tbl[10] = mkv(0,1,0,0,32'h111,32'hAABBCCDD,32'h0,1,1, 2,32'h0,0,4'h2,32'hDDDDDDDD,1);
        tbl[11] = mkv(1,0,3,0,32'h10C,32'h0,32'h0BADF00D,1,1, 3,32'h0BADF00D,0,4'hF,32'h0,1);
        tbl[12] = mkv(1,0,1,0,32'h103,32'h0,32'h0,1,1, 1,32'h0,1,4'h0,32'h0,0);
        tbl[13] = mkv(1,1,2,0,32'h120,32'hCAFEF00D,32'h0,1,1, 2,32'h0,0,4'hF,32'hCAFEF00D,1);
        tbl[14] = mkv(0,1,2,0,32'h102,32'h0,32'h0,1,1, 1,32'h0,1,4'h0,32'h0,0);
        tbl[15] = mkv(1,0,0,1,32'h101,32'h0,32'h0000AB00,3,1, 5,32'h000000AB,0,4'h2,32'h0,3);
        tbl[16] = mkv(1,0,2,0,32'h140,32'h0,32'h0,4,1, 5,32'h0,2,4'hF,32'h0,4);

        reset = 1'b1;
        req_valid_i = 1'b0; alu_res_i = '0; store_data_i = '0;
        mem_rd_i = 1'b0; mem_wr_i = 1'b0; size_i = '0; zero_extnd_i = 1'b0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        step();
        step();
        chk("reset bus_req", bus_req_o, 0);
        chk("reset bus_we", bus_we_o, 0);
        chk("reset bus_addr", bus_addr_o, 0);
        chk("reset bus_be", {28'h0, bus_be_o}, 0);
        chk("reset bus_wdata", bus_wdata_o, 0);
        chk("reset rsp_valid", rsp_valid_o, 0);
        chk("reset rsp_data", rsp_data_o, 0);
        chk("reset rsp_err", {30'h0, rsp_err_o}, 0);
        reset = 1'b0;
        step();
        chk("post-reset ready", req_ready_o, 1);

        for (int i = 0; i < 17; i++) run_access(tbl[i], $sformatf("vec%0d", i));

        // Reset while requesting: bus_req_o must fall without a clock edge.
        v = tbl[6];
        req_valid_i = 1'b1; mem_rd_i = 1'b1; mem_wr_i = 1'b0; size_i = 2'd2;
        alu_res_i = 32'h400; bus_gnt_i = 1'b0;
        step();
        req_valid_i = 1'b0;
        chk("rstREQ bus_req before", bus_req_o, 1);
        #2 reset = 1'b1;
        #1;
        chk("rstREQ bus_req async", bus_req_o, 0);
        chk("rstREQ rsp_valid async", rsp_valid_o, 0);
        step();
        reset = 1'b0;
        step();
        chk("rstREQ ready", req_ready_o, 1);

        // Reset while waiting for read data, followed by a late rvalid.
        req_valid_i = 1'b1; mem_rd_i = 1'b1; mem_wr_i = 1'b0; size_i = 2'd2;
        alu_res_i = 32'h500;
        step();
        req_valid_i = 1'b0;
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0;
        chk("rstWAIT bus_req in wait", bus_req_o, 0);
        #2 reset = 1'b1;
        #1;
        chk("rstWAIT rsp_valid async", rsp_valid_o, 0);
        step();
        reset = 1'b0;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'hBAD0BAD0;
        step();
        bus_rvalid_i = 1'b0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid_o) cnt++;
            step();
        end
        chk("rstWAIT late rvalid no rsp", cnt, 0);
        chk("rstWAIT ready", req_ready_o, 1);
        run_access(v, "after-reset");
        run_access(tbl[0], "after-reset-lw");

        for (int i = 0; i < 150; i++) begin
            int op;
            op     = $urandom_range(0, 9);
            v.rd   = (op >= 1 && op <= 5) || op == 9;
            v.wr   = (op >= 6);
            v.size = 2'($urandom_range(0, 3));
            v.zext = 1'($urandom);
            v.addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (v.size == 2'd1)     v.addr[0]   = 1'b0;
                else if (v.size[1])     v.addr[1:0] = 2'b00;
            end
            v.sdata = $urandom;
            v.rdata = $urandom;
            v.g     = $urandom_range(0, 5);
            v.w     = $urandom_range(1, 4);
            v = model(v);
            run_access(v, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
